// File: rtl/cpu_alu_pkg.sv
// Shared CPU definitions: instruction opcodes, internal ALU operations and flag layout.
// Used by the ALU, its decoder and the datapath.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 5;
    localparam int OP_W   = 3;
    localparam int FLAG_W = 2;

    typedef logic [OPC_W-1:0]  opcode_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam opcode_t OPC_ADD   = 5'b00010;
    localparam opcode_t OPC_ADDI  = 5'b00011;
    localparam opcode_t OPC_SUB   = 5'b00100;
    localparam opcode_t OPC_SUBI  = 5'b00101;
    localparam opcode_t OPC_MUL   = 5'b00110;
    localparam opcode_t OPC_MOVEH = 5'b00111;
    localparam opcode_t OPC_DIV   = 5'b01000;
    localparam opcode_t OPC_AND   = 5'b01010;
    localparam opcode_t OPC_ANDI  = 5'b01011;
    localparam opcode_t OPC_OR    = 5'b01100;
    localparam opcode_t OPC_ORI   = 5'b01101;
    localparam opcode_t OPC_NOT   = 5'b01110;
    localparam opcode_t OPC_XOR   = 5'b10000;
    localparam opcode_t OPC_XORI  = 5'b10001;
    localparam opcode_t OPC_CMP   = 5'b10010;
    localparam opcode_t OPC_CALL  = 5'b10100;
    localparam opcode_t OPC_RET   = 5'b10101;
    localparam opcode_t OPC_RETI  = 5'b10110;
    localparam opcode_t OPC_ST    = 5'b11100;
    localparam opcode_t OPC_LD    = 5'b11101;
    localparam opcode_t OPC_MOVEL = 5'b11110;

    typedef enum logic [OP_W-1:0] {
        ADDA = 3'b000,
        SUBA = 3'b001,
        MULA = 3'b010,
        DIVA = 3'b011,
        ANDA = 3'b100,
        ORA  = 3'b101,
        XORA = 3'b110,
        NOTA = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // N is a signed less-than, Z is plain equality.
    function automatic logic [FLAG_W-1:0] cmp_flags(input word_t a, input word_t b);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_N] = ($signed(a) < $signed(b));
        f[FLAG_Z] = (a == b);
        return f;
    endfunction

endpackage

// File: rtl/cpu_alu_if.sv
// Operand/result bundle between the execute-stage datapath (master) and the ALU (slave).
interface cpu_alu_if;
    import cpu_pkg::*;

    word_t                a;
    word_t                b;
    opcode_t              opcode;
    word_t                alu_out;
    logic [FLAG_W-1:0]    flags;

    modport master (
        output a,
        output b,
        output opcode,
        input  alu_out,
        input  flags
    );

    modport slave (
        input  a,
        input  b,
        input  opcode,
        output alu_out,
        output flags
    );

endinterface

// File: rtl/cpu_alu_decode.sv
// Combinational opcode -> internal ALU operation decode.
module alu_decode
    import cpu_pkg::*;
(
    input  opcode_t i_opcode,
    output alu_op_e o_op
);

    // Memory ops use the adder for address generation; MOVEH/MOVEL are masks applied through AND.
    always_comb begin
        o_op = ADDA;
        case (i_opcode)
            OPC_ADD, OPC_ADDI, OPC_ST, OPC_LD:         o_op = ADDA;
            OPC_SUB, OPC_SUBI, OPC_CMP:                o_op = SUBA;
            OPC_MUL:                                   o_op = MULA;
            OPC_DIV:                                   o_op = DIVA;
            OPC_AND, OPC_ANDI, OPC_MOVEH, OPC_MOVEL:   o_op = ANDA;
            OPC_OR, OPC_ORI:                           o_op = ORA;
            OPC_XOR, OPC_XORI:                         o_op = XORA;
            OPC_NOT:                                   o_op = NOTA;
            default:                                   o_op = ADDA;
        endcase
    end

endmodule

// File: rtl/cpu_alu.sv
// 32-bit execute-stage ALU: combinational result plus the CMP-written N/Z flag register.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cpu_alu_if.slave     bus
);

    alu_op_e             op;
    word_t               w_result;
    word_t               w_quot;
    logic                w_is_cmp;
    logic [FLAG_W-1:0]   w_cmp_flags;
    logic [FLAG_W-1:0]   r_flags;

    alu_decode u_alu_decode (
        .i_opcode (bus.opcode),
        .o_op     (op)
    );

    // Divide-by-zero returns all ones rather than trapping.
    assign w_quot = (bus.b == '0) ? '1 : (bus.a / bus.b);

    always_comb begin
        w_result = '0;
        case (op)
            ADDA:    w_result = bus.a + bus.b;
            SUBA:    w_result = bus.a - bus.b;
            MULA:    w_result = bus.a * bus.b;
            DIVA:    w_result = w_quot;
            ANDA:    w_result = bus.a & bus.b;
            ORA:     w_result = bus.a | bus.b;
            XORA:    w_result = bus.a ^ bus.b;
            NOTA:    w_result = ~bus.a;
            default: w_result = '0;
        endcase
    end

    assign w_is_cmp    = (bus.opcode == OPC_CMP);
    assign w_cmp_flags = cmp_flags(bus.a, bus.b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_is_cmp) begin
            r_flags <= w_cmp_flags;
        end
    end

    assign bus.alu_out = w_result;
    assign bus.flags   = r_flags;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu: directed and random stimulus against a behavioural model.
module tb_cpu_alu;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;

    cpu_alu_if bus ();

    cpu_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [2:0]  op;
        logic [1:0]  flg;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 0;

    logic [1:0] model_flags;

    function automatic logic [2:0] model_op(input logic [4:0] opc);
        case (opc)
            5'b00010, 5'b00011, 5'b11100, 5'b11101: return 3'b000;
            5'b00100, 5'b00101, 5'b10010:           return 3'b001;
            5'b00110:                               return 3'b010;
            5'b01000:                               return 3'b011;
            5'b01010, 5'b01011, 5'b00111, 5'b11110: return 3'b100;
            5'b01100, 5'b01101:                     return 3'b101;
            5'b10000, 5'b10001:                     return 3'b110;
            5'b01110:                               return 3'b111;
            default:                                return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub;
        ua = a;
        ub = b;
        case (o)
            3'b000: return 32'((ua + ub) % 64'h1_0000_0000);
            3'b001: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
            3'b010: return 32'((ua * ub) % 64'h1_0000_0000);
            3'b011: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'b100: return a & b;
            3'b101: return a | b;
            3'b110: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // One stimulus per cycle, applied 1 time unit after the rising edge.
    // mid_rst asserts reset partway through the cycle, before the monitor samples.
    task automatic issue(input string nm, input logic [4:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input bit mid_rst);
        exp_t e;
        @(posedge clk);
        if (rst_n && bus.opcode == 5'b10010)
            model_flags = {($signed(bus.a) < $signed(bus.b)), (bus.a == bus.b)};
        #1;
        bus.opcode = opc;
        bus.a      = a;
        bus.b      = b;
        if (mid_rst) begin
            #1;
            rst_n = 1'b0;
        end
        if (!rst_n) model_flags = 2'b00;
        e.name = nm;
        e.op   = model_op(opc);
        e.alu  = model_res(e.op, a, b);
        e.flg  = model_flags;
        q.push_back(e);
    endtask

    task automatic release_rst();
        @(posedge clk);
        if (rst_n && bus.opcode == 5'b10010)
            model_flags = {($signed(bus.a) < $signed(bus.b)), (bus.a == bus.b)};
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.alu_out !== e.alu) begin
                failures++;
                $display("FAIL %s alu_out: got %h expected %h", e.name, bus.alu_out, e.alu);
            end
            checks++;
            if (3'(dut.op) !== e.op) begin
                failures++;
                $display("FAIL %s op: got %b expected %b", e.name, 3'(dut.op), e.op);
            end
            checks++;
            if (bus.flags !== e.flg) begin
                failures++;
                $display("FAIL %s flags: got %b expected %b", e.name, bus.flags, e.flg);
            end
        end
    end

    logic [4:0] opc_list [18] = '{5'b00010, 5'b00011, 5'b11100, 5'b11101, 5'b00100, 5'b00101,
                                  5'b10010, 5'b00110, 5'b01000, 5'b01010, 5'b01011, 5'b00111,
                                  5'b11110, 5'b01100, 5'b01101, 5'b10000, 5'b10001, 5'b01110};

    initial begin
        rst_n       = 1'b0;
        model_flags = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.opcode  = 5'b00010;

        issue("reset_state", 5'b00010, 32'd1, 32'd2, 0);
        issue("reset_cmp_ignored", 5'b10010, 32'd3, 32'd3, 0);
        release_rst();

        foreach (opc_list[i]) begin
            issue("decode_sweep", opc_list[i], 32'h1234_5678, 32'h0000_0011, 0);
            issue("decode_sweep_hold", opc_list[i], 32'h1234_5678, 32'h0000_0011, 0);
        end
        issue("decode_unlisted", 5'b11111, 32'd10, 32'd20, 0);
        issue("decode_call", 5'b10100, 32'd10, 32'd20, 0);

        issue("add_wrap", 5'b00010, 32'hFFFF_FFFF, 32'd1, 0);
        issue("sub_neg", 5'b00100, 32'd5, 32'd7, 0);
        issue("mul_low", 5'b00110, 32'h0001_0000, 32'h0001_0000, 0);
        issue("div", 5'b01000, 32'd100, 32'd7, 0);
        issue("div_zero", 5'b01000, 32'd100, 32'd0, 0);
        issue("and", 5'b01010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        issue("or", 5'b01100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        issue("xor", 5'b10000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
        issue("not", 5'b01110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);

        issue("cmp_eq", 5'b10010, 32'd3, 32'd3, 0);
        issue("cmp_lt", 5'b10010, 32'hFFFF_FFFF, 32'd2, 0);
        issue("cmp_gt", 5'b10010, 32'd9, 32'd2, 0);
        issue("cmp_eq2", 5'b10010, 32'd3, 32'd3, 0);
        issue("add_hold", 5'b00010, 32'd4, 32'd5, 0);
        issue("add_hold2", 5'b00010, 32'd6, 32'd7, 0);

        issue("reset_mid_cycle", 5'b00010, 32'd1, 32'd1, 1);
        issue("reset_mid_cmp", 5'b10010, 32'd3, 32'd3, 0);
        release_rst();
        issue("post_reset_hold", 5'b00010, 32'd1, 32'd1, 0);
        issue("post_reset_cmp", 5'b10010, 32'hFFFF_FFF0, 32'd1, 0);
        issue("post_reset_after_cmp", 5'b00110, 32'd3, 32'd5, 0);

        for (int i = 0; i < 300; i++) begin
            logic [4:0]  ro;
            logic [31:0] ra, rb;
            ro = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ro = 5'b10010;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: rb = 32'd0;
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue("random", ro, ra, rb, 0);
        end
        stim_done = 1;
    end

    initial begin
        int waited;
        wait (stim_done);
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries pending, expected 0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_alu.md
# cpu_alu

The `cpu_alu` block is the 32-bit arithmetic/logic unit of the CPU execute stage. It decodes the 5-bit instruction opcode into a 3-bit internal ALU operation. It produces a combinational 32-bit result from operands `a` and `b`, and holds a 2-bit condition-flag register. The flag register is written by compare instructions and read by branch logic.

## Interface
- Parameters: none (widths fixed: data 32, opcode 5, internal op 3, flags 2).
- `clk` input 1: single clock; the flag register updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `a` input 32: operand A (rs value).
- `b` input 32: operand B (rt value or extended immediate/mask, supplied by the datapath).
- `opcode` input 5: instruction opcode.
- `alu_out` output 32: combinational result.
- `flags` output 2: registered condition flags; `flags[1]` = N (less-than), `flags[0]` = Z (equal).

## Operation
- The internal 3-bit signal must be named `op`. Verification probes it hierarchically as `op`.
- `op` encodings:
  - ADDA=000, SUBA=001, MULA=010, DIVA=011
  - ANDA=100, ORA=101, XORA=110, NOTA=111
- Opcode to `op` decode (purely combinational):
  - ADD 00010, ADDI 00011, ST 11100, LD 11101 -> ADDA
  - SUB 00100, SUBI 00101, CMP 10010 -> SUBA
  - MUL 00110 -> MULA
  - DIV 01000 -> DIVA
  - AND 01010, ANDI 01011, MOVEH 00111, MOVEL 11110 -> ANDA
  - OR 01100, ORI 01101 -> ORA
  - XOR 10000, XORI 10001 -> XORA
  - NOT 01110 -> NOTA
  - every other opcode -> ADDA
- Result by `op`:
  - ADDA: `a+b` mod 2^32.
  - SUBA: `a-b` mod 2^32.
  - MULA: low 32 bits of the unsigned product.
  - DIVA: unsigned `a/b`; when b==0, result is 32'hFFFF_FFFF.
  - ANDA: `a&b`. MOVEH/MOVEL rely on the datapath to provide the mask in `b`.
  - ORA: `a|b`. XORA: `a^b`. NOTA: `~a` (`b` ignored).
- No carry or overflow outputs; arithmetic wraps silently.
- Flags:
  - Written only when opcode==CMP.
  - Z <= (a==b). N <= ($signed(a) < $signed(b)).
  - All other opcodes hold the flag register.

## Timing
- `op` and `alu_out` are combinational from `opcode`/`a`/`b`: zero-cycle latency, valid within the same cycle. Reset has no effect on them.
- `flags` is registered: a CMP presented before rising edge k is visible on `flags` after edge k. Hold it for consecutive non-CMP cycles.
- Reset: `rst_n` low forces `flags` to 2'b00 immediately, independent of `clk`. It holds 2'b00 while low, including when asserted in the middle of a CMP. The first update occurs at the first rising edge after deassertion.
- Back-to-back CMPs: each edge takes the latest operands; there is no pipelining or stall.

## Structure
- Shared package `cpu_pkg`: the 5-bit opcode constants (ADD...MOVEL, CALL, RET, RETI) and the 3-bit ALU op constants/enum (ADDA...NOTA). These are shared with the decoder and datapath.
- One natural sub-module: `alu_decode` (opcode -> op, combinational case). Its output must be wired to a signal named `op` inside `cpu_alu`.
- Datapath case on `op` plus the flag flop stay in `cpu_alu`.

## Test plan
- Decode sweep: drive each listed opcode, wait 2 cycles, check `op`. For example, ADD/ADDI/LD/ST -> 000, CMP -> 001, MOVEH/MOVEL -> 100, NOT -> 111, DIV -> 011. Unlisted opcode 11111 -> 000.
- Arithmetic:
  - ADD a=32'hFFFF_FFFF, b=1 -> 0.
  - SUB a=5, b=7 -> 32'hFFFF_FFFE.
  - MUL a=32'h0001_0000, b=32'h0001_0000 -> 0.
  - DIV a=100, b=7 -> 14.
  - DIV b=0 -> 32'hFFFF_FFFF.
- Logic: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0.
  - AND -> 32'h00F0_00F0.
  - OR -> 32'hFFF0_FFF0.
  - XOR -> 32'hFF00_FF00.
  - NOT -> 32'h0F0F_0F0F.
- Flags:
  - CMP a=3, b=3 -> after edge, flags=01.
  - CMP a=-1, b=2 -> flags=10.
  - CMP a=9, b=2 -> flags=00.
  - A following ADD leaves flags unchanged.
- Reset: after CMP sets flags=01, assert `rst_n` low mid-cycle -> flags=00 without a clock edge. Flags stay 00 until the next CMP after deassertion.
